postcode_display_scanner: RTL and testbench

Time-multiplexed driver for the shared front-panel POST display bus: two 7-segment digits plus an 8-LED status bank, all on one 8-bit LED_CONTROL bus. Sits directly upstream of the non-PFR board-level passthrough. It produces the cc-side LED_CONTROL_[7:0], FM_POST_7SEG1_SEL_N, FM_POST_7SEG2_SEL_N and FM_POSTLED_SEL signals, which that stage routes to pins. Captures the BIOS/BMC POST code byte and scans DIGIT1 (high nibble), DIGIT2 (low nibble) and LEDS phases, with enforced dead-time between phases.

---
 rtl/postcode_display_scanner.sv | 124 ++++++++++++
 tb/tb_postcode_display_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/postcode_display_scanner.sv
// Time-multiplexed POST display driver: two 7-segment digits and an 8-LED bank
// share one active-low LED_CONTROL bus, with enforced dead-time between phases.
module postcode_display_scanner #(
  parameter int DWELL_MS      = 4,
  parameter int DEADTIME_CLKS = 4
) (
  input  logic       clk2M,
  input  logic       reset,
  input  logic       i1mSCE,
  input  logic       i_display_en,
  input  logic [7:0] i_postcode,
  input  logic       i_postcode_valid,
  input  logic [7:0] i_status_leds,
  input  logic       i_dp_en,
  output logic [7:0] o_led_control,
  output logic       o_7seg1_sel_n,
  output logic       o_7seg2_sel_n,
  output logic       o_postled_sel
);

  typedef enum logic [2:0] {BLANK, DEAD, DIGIT1, DIGIT2, LEDS} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_MS - 1);
  localparam logic [3:0] DEAD_LAST  = 4'(DEADTIME_CLKS - 1);

  state_t     state;
  state_t     next_phase;
  logic [7:0] pending;
  logic [7:0] shadow;
  logic [7:0] dwell_cnt;
  logic [3:0] dead_cnt;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg(input logic [3:0] n);
    // NOTE: the default arm keeps every path assigned, so no latch is inferred.
    case (n)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] phase_data(input state_t ph, input logic [7:0] code,
                                            input logic dp_en, input logic [7:0] leds);
    case (ph)
      DIGIT1:  phase_data = {1'b1, seg(code[7:4])};
      DIGIT2:  phase_data = {~dp_en, seg(code[3:0])};
      LEDS:    phase_data = ~leds;
      default: phase_data = 8'hFF;
    endcase
  endfunction

  // Capture runs regardless of display enable so the code is current on re-enable.
  always_ff @(posedge clk2M or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset)                 pending <= 8'h00;
    else if (i_postcode_valid) pending <= i_postcode;
  end

  always_ff @(posedge clk2M or posedge reset) begin
    if (reset) begin
      state         <= BLANK;
      next_phase    <= DIGIT1;
      shadow        <= 8'h00;
      dwell_cnt     <= 8'h00;
      dead_cnt      <= 4'h0;
      o_led_control <= 8'hFF;
      o_7seg1_sel_n <= 1'b1;
      o_7seg2_sel_n <= 1'b1;
      o_postled_sel <= 1'b0;
    end else if (!i_display_en) begin
      state         <= BLANK;
      next_phase    <= DIGIT1;
      dwell_cnt     <= 8'h00;
      dead_cnt      <= 4'h0;
      o_led_control <= 8'hFF;
      o_7seg1_sel_n <= 1'b1;
      o_7seg2_sel_n <= 1'b1;
      o_postled_sel <= 1'b0;
    end else begin
      case (state)
        BLANK: begin
          state      <= DEAD;
          next_phase <= DIGIT1;
          dead_cnt   <= 4'h0;
        end
        DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            // Select and data go live on the same edge; DIGIT1 latches the frame's code.
            state         <= next_phase;
            dwell_cnt     <= 8'h00;
            o_7seg1_sel_n <= (next_phase != DIGIT1);
            o_7seg2_sel_n <= (next_phase != DIGIT2);
            o_postled_sel <= (next_phase == LEDS);
            if (next_phase == DIGIT1) shadow <= pending;
            o_led_control <= phase_data(next_phase, (next_phase == DIGIT1) ? pending : shadow,
                                        i_dp_en, i_status_leds);
          end else begin
            dead_cnt <= dead_cnt + 4'h1;
          end
        end
        DIGIT1, DIGIT2, LEDS: begin
          if (i1mSCE && dwell_cnt == DWELL_LAST) begin
            state         <= DEAD;
            dead_cnt      <= 4'h0;
            next_phase    <= (state == DIGIT1) ? DIGIT2 : (state == DIGIT2) ? LEDS : DIGIT1;
            o_led_control <= 8'hFF;
            o_7seg1_sel_n <= 1'b1;
            o_7seg2_sel_n <= 1'b1;
            o_postled_sel <= 1'b0;
          end else begin
            if (i1mSCE) dwell_cnt <= dwell_cnt + 8'h01;
            o_led_control <= phase_data(state, shadow, i_dp_en, i_status_leds);
          end
        end
        default: begin
          state <= BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_postcode_display_scanner.sv
// Bench for postcode_display_scanner: a phase-schedule model is checked against the
// DUT every cycle, with directed literal checks and a random run.
module tb_postcode_display_scanner;

  localparam int DWELL    = 4;
  localparam int DEADTIME = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i1msce = 1'b0;
  logic       en = 1'b0;
  logic [7:0] postcode = 8'h00;
  logic       valid = 1'b0;
  logic [7:0] status = 8'h00;
  logic       dp = 1'b0;
  logic [7:0] led;
  logic       s1n, s2n, pl;

  bit sce_auto = 1'b1;
  bit sce_force = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  postcode_display_scanner #(.DWELL_MS(DWELL), .DEADTIME_CLKS(DEADTIME)) dut (
    .clk2M(clk), .reset(rst), .i1mSCE(i1msce), .i_display_en(en),
    .i_postcode(postcode), .i_postcode_valid(valid), .i_status_leds(status),
    .i_dp_en(dp), .o_led_control(led), .o_7seg1_sel_n(s1n),
    .o_7seg2_sel_n(s2n), .o_postled_sel(pl)
  );

  initial forever #5 clk = ~clk;

  // Millisecond enable: random isolated pulses, or directed pulses when sce_auto is off.
  initial forever begin
    @(negedge clk);
    #1;
    if (sce_auto) i1msce = !i1msce && ($urandom_range(0, 2) == 0);
    else          i1msce = sce_force;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a display schedule walking D1 -> D2 -> LEDS with dead gaps.
  typedef enum {M_BLANK, M_DEAD, M_D1, M_D2, M_LEDS} mphase_t;
  mphase_t    m_phase = M_BLANK;
  mphase_t    m_next = M_D1;
  int         m_dead_left = 0;
  int         m_pulses = 0;
  logic [7:0] m_pending = 8'h00;
  logic [7:0] m_shadow = 8'h00;
  logic [7:0] exp_led = 8'hFF;
  logic       exp_s1n = 1'b1, exp_s2n = 1'b1, exp_pl = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = M_BLANK; m_next = M_D1; m_pending = 8'h00; m_shadow = 8'h00;
      m_pulses = 0; m_dead_left = 0;
    end else begin
      if (!en) m_phase = M_BLANK;
      else if (m_phase == M_BLANK) begin
        m_phase = M_DEAD; m_next = M_D1; m_dead_left = DEADTIME;
      end else if (m_phase == M_DEAD) begin
        m_dead_left--;
        if (m_dead_left == 0) begin
          m_phase = m_next;
          m_pulses = 0;
          if (m_phase == M_D1) m_shadow = m_pending;
        end
      end else if (i1msce) begin
        m_pulses++;
        if (m_pulses == DWELL) begin
          case (m_phase)
            M_D1:    m_next = M_D2;
            M_D2:    m_next = M_LEDS;
            default: m_next = M_D1;
          endcase
          m_phase = M_DEAD;
          m_dead_left = DEADTIME;
        end
      end
      if (valid) m_pending = postcode;
    end
    exp_s1n = (m_phase != M_D1);
    exp_s2n = (m_phase != M_D2);
    exp_pl  = (m_phase == M_LEDS);
    case (m_phase)
      M_D1:    exp_led = seg_tab[m_shadow[7:4]];
      M_D2:    exp_led = {~dp, seg_tab[m_shadow[3:0]][6:0]};
      M_LEDS:  exp_led = ~status;
      default: exp_led = 8'hFF;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      check("model_led", led, exp_led);
      check("model_sel1_n", 8'(s1n), 8'(exp_s1n));
      check("model_sel2_n", 8'(s2n), 8'(exp_s2n));
      check("model_postled", 8'(pl), 8'(exp_pl));
    end
  end

  // Select-bus safety: one select at most, no direct handover, full dead gap.
  initial begin
    int         gap;
    bit         seen;
    logic [2:0] prev, cur;
    gap = 0; seen = 1'b0; prev = 3'b000;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        cur = {pl, ~s2n, ~s1n};
        check("one_select", 8'($countones(cur) <= 1), 8'd1);
        if (cur == 3'b000) gap++;
        else begin
          if (prev == 3'b000 && seen) check("dead_gap", 8'(gap >= DEADTIME), 8'd1);
          if (prev != 3'b000) check("no_handover", 8'(cur), 8'(prev));
          seen = 1'b1;
          gap = 0;
        end
        prev = cur;
      end
    end
  end

  function automatic bit sel_on(input int which);
    case (which)
      1:       sel_on = !s1n;
      2:       sel_on = !s2n;
      default: sel_on = pl;
    endcase
  endfunction

  // Wait for a phase's select; gap counts negedges seen with every select idle.
  task automatic wait_sel(input int which, output int gap);
    bit hit;
    gap = 0;
    hit = 1'b0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      @(negedge clk);
      if (sel_on(which)) hit = 1'b1;
      else if (s1n && s2n && !pl) gap++;
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_sel%0d: got timeout expected select", which);
    end
  endtask

  task automatic strobe(input logic [7:0] code);
    postcode = code;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    int g;
    status = 8'h05;
    repeat (3) @(negedge clk);
    check("rst_led", led, 8'hFF);
    check("rst_sel1_n", 8'(s1n), 8'd1);
    check("rst_sel2_n", 8'(s2n), 8'd1);
    check("rst_postled", 8'(pl), 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frame with 3A, then the LED bank.
    en = 1'b1; postcode = 8'h3A; valid = 1'b1;
    wait_sel(1, g);
    valid = 1'b0;
    check("t1_dead_before_d1", 8'(g), 8'(DEADTIME));
    check("t1_d1_led", led, 8'hB0);
    wait_sel(2, g);
    check("t1_dead_before_d2", 8'(g), 8'(DEADTIME));
    check("t1_d2_led", led, 8'h88);
    wait_sel(3, g);
    check("t1_dead_before_leds", 8'(g), 8'(DEADTIME));
    check("t2_leds_led", led, 8'hFA);

    // Decimal point on code 00.
    strobe(8'h00);
    dp = 1'b1;
    wait_sel(1, g);
    wait_sel(2, g);
    check("t2_dp_led", led, 8'h40);
    dp = 1'b0;

    // Tear-free update.
    strobe(8'h12);
    wait_sel(1, g);
    check("t3_d1_12", led, 8'hF9);
    wait_sel(2, g);
    strobe(8'h55);
    if (!s2n === 1'b1) check("t3_d2_holds_2", led, 8'hA4);
    wait_sel(1, g);
    check("t3_d1_55", led, 8'h92);
    wait_sel(3, g);
    sce_auto = 1'b0;
    for (int k = 0; k < DWELL; k++) begin
      sce_force = 1'b1;
      @(negedge clk);
      sce_force = 1'b0;
      if (k < DWELL - 1) @(negedge clk);
    end
    repeat (DEADTIME - 1) @(negedge clk);
    postcode = 8'h77; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("t3_entry_sel1_n", 8'(s1n), 8'd0);
    check("t3_entry_old_code", led, 8'h92);
    sce_auto = 1'b1;
    wait_sel(2, g);
    check("t3_d2_old_code", led, 8'h92);
    wait_sel(1, g);
    check("t3_d1_new_code", led, 8'hF8);

    // Display enable drop in DIGIT1 and re-enable.
    en = 1'b0;
    @(negedge clk);
    check("t4_blank_led", led, 8'hFF);
    check("t4_blank_sels", 8'({s1n, s2n, pl}), 8'b110);
    en = 1'b1;
    wait_sel(1, g);
    check("t4_reenable_dead", 8'(g), 8'(DEADTIME));

    // Asynchronous reset mid-LEDS.
    wait_sel(3, g);
    #2 rst = 1'b1;
    #1;
    check("t5_async_postled", 8'(pl), 8'd0);
    check("t5_async_led", led, 8'hFF);
    check("t5_async_sels", 8'({s1n, s2n}), 8'b11);
    @(negedge clk);
    rst = 1'b0;

    // Nibble sweep through both digits.
    for (int i = 0; i < 16; i++) begin
      wait_sel(3, g);
      strobe({4'(i), 4'(15 - i)});
      wait_sel(1, g);
      check("sweep_d1", led, seg_tab[i]);
      wait_sel(2, g);
      check("sweep_d2", led, seg_tab[15 - i]);
    end

    // Random run covered by the model and the select monitor.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      valid    = ($urandom_range(0, 19) == 0);
      postcode = 8'($urandom);
      status   = 8'($urandom);
      dp       = 1'($urandom);
      en       = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
